// File: rtl/six_op_pipe.sv
// six_op_pipe: six operands in, three results out, through a two-register
// pipeline (S1 operands, S2 results) with valid/ready handshakes at both ends
// and a wrapping count of delivered result sets.
module six_op_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic [2:0]       ovf,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_LOGIC = 2'd2,
        OP_SEL   = 2'd3
    } op_e;

    // S1: registered operands and operation
    logic             s1_valid_q;
    op_e              s1_mode_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q, s1_d_q, s1_e_q, s1_f_q;

    // S2: registered results
    logic             s2_valid_q;
    logic [WIDTH-1:0] x_q, y_q, z_q;
    logic [2:0]       ovf_q;
    logic [WIDTH-1:0] x_d, y_d, z_d;
    logic [2:0]       ovf_d;

    logic [CNT_W-1:0] cnt_q;

    logic s1_adv, s2_adv;

    // One extra bit carries the carry (add) or the borrow (sub, wraps negative)
    logic [WIDTH:0] sum_ab, sum_cd, sum_ef;
    logic [WIDTH:0] dif_ab, dif_cd, dif_ef;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign out_valid = s2_valid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;
    assign ovf       = ovf_q;
    assign done_cnt  = cnt_q;

    assign sum_ab = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign sum_cd = {1'b0, s1_c_q} + {1'b0, s1_d_q};
    assign sum_ef = {1'b0, s1_e_q} + {1'b0, s1_f_q};
    assign dif_ab = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    assign dif_cd = {1'b0, s1_c_q} - {1'b0, s1_d_q};
    assign dif_ef = {1'b0, s1_e_q} - {1'b0, s1_f_q};

    // Result datapath selected by the mode captured alongside the operands
    always_comb begin
        x_d   = '0;
        y_d   = '0;
        z_d   = '0;
        ovf_d = '0;
        case (s1_mode_q)
            OP_ADD: begin
                x_d   = sum_ab[WIDTH-1:0];
                y_d   = sum_cd[WIDTH-1:0];
                z_d   = sum_ef[WIDTH-1:0];
                ovf_d = {sum_ef[WIDTH], sum_cd[WIDTH], sum_ab[WIDTH]};
            end
            OP_SUB: begin
                x_d   = dif_ab[WIDTH-1:0];
                y_d   = dif_cd[WIDTH-1:0];
                z_d   = dif_ef[WIDTH-1:0];
                ovf_d = {dif_ef[WIDTH], dif_cd[WIDTH], dif_ab[WIDTH]};
            end
            OP_LOGIC: begin
                x_d = s1_a_q & s1_b_q;
                y_d = s1_c_q | s1_d_q;
                z_d = s1_e_q ^ s1_f_q;
            end
            OP_SEL: begin
                x_d = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
                y_d = (s1_c_q <= s1_d_q) ? s1_c_q : s1_d_q;
                // average keeps the carry bit, so the halved value always fits
                z_d = sum_ef[WIDTH:1];
            end
            default: begin
                x_d   = '0;
                y_d   = '0;
                z_d   = '0;
                ovf_d = '0;
            end
        endcase
    end

    // S1 capture: accepts a new set whenever the stage is empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= OP_ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
            s1_d_q     <= '0;
            s1_e_q     <= '0;
            s1_f_q     <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_mode_q <= op_e'(mode);
                s1_a_q    <= a;
                s1_b_q    <= b;
                s1_c_q    <= c;
                s1_d_q    <= d;
                s1_e_q    <= e;
                s1_f_q    <= f;
            end
        end
    end

    // S2 capture: results held stable while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            ovf_q      <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                x_q   <= x_d;
                y_q   <= y_d;
                z_q   <= z_d;
                ovf_q <= ovf_d;
            end
        end
    end

    // Delivered-set counter, one per output handshake, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (s2_valid_q && out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_six_op_pipe.sv
// Directed bench for six_op_pipe: table vectors, latency, backpressure,
// streaming, counter wrap (CNT_W=4) and asynchronous reset mid-flight.
module tb_six_op_pipe;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a, b, c, d, e, f;
        logic [W-1:0] ex, ey, ez;
        logic [2:0]   eovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] x, y, z;
        logic [2:0]   ovf;
    } res_t;

    logic          clk, rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    mode;
    logic [W-1:0]  a, b, c, d, e, f, x, y, z;
    logic [2:0]    ovf;
    logic [CW-1:0] done_cnt;

    six_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .z(z), .ovf(ovf), .done_cnt(done_cnt)
    );

    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   hs_total = 0;
    int   run = 0;
    int   max_run = 0;
    res_t exp_q[$];
    vec_t tbl[10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t exp_of(input vec_t v);
        res_t r;
        r.x = v.ex; r.y = v.ey; r.z = v.ez; r.ovf = v.eovf;
        return r;
    endfunction

    // Reference for one operand pair; k selects which result lane (x,y,z)
    function automatic void lane(input int unsigned m, input int unsigned p,
                                 input int unsigned q, input int k,
                                 output logic [W-1:0] res, output logic fl);
        int unsigned s;
        fl = 1'b0;
        case (m)
            0: begin s = p + q; res = W'(s % 256); fl = (s >= 256); end
            1: begin res = W'((p + 256 - q) % 256); fl = (p < q); end
            2: res = (k == 0) ? W'(p & q) : (k == 1) ? W'(p | q) : W'(p ^ q);
            default: res = (k == 0) ? W'((p > q) ? p : q)
                         : (k == 1) ? W'((p < q) ? p : q) : W'((p + q) / 2);
        endcase
    endfunction

    function automatic vec_t modelled(input vec_t v);
        vec_t r = v;
        lane(v.mode, v.a, v.b, 0, r.ex, r.eovf[0]);
        lane(v.mode, v.c, v.d, 1, r.ey, r.eovf[1]);
        lane(v.mode, v.e, v.f, 2, r.ez, r.eovf[2]);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        mode = v.mode; a = v.a; b = v.b; c = v.c; d = v.d; e = v.e; f = v.f;
        in_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input vec_t v);
        bit ok = 0;
        drive(v);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp_of(v));
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clean_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Output monitor: every handshake checks results in order and the counter
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                run = out_valid ? run + 1 : 0;
                if (run > max_run) max_run = run;
                if (out_valid && out_ready) begin
                    chk("done_cnt_at_hs", done_cnt, model_cnt);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out: got x=%0h y=%0h z=%0h ovf=%b, none expected",
                                 x, y, z, ovf);
                    end else begin
                        r = exp_q.pop_front();
                        if ({x, y, z, ovf} !== {r.x, r.y, r.z, r.ovf}) begin
                            errors++;
                            $display("FAIL result: got x=%0h y=%0h z=%0h ovf=%b expected x=%0h y=%0h z=%0h ovf=%b",
                                     x, y, z, ovf, r.x, r.y, r.z, r.ovf);
                        end
                    end
                    model_cnt = (model_cnt + 1) % (1 << CW);
                    hs_total++;
                end
            end
        end
    end

    initial begin
        vec_t   v;
        longint t0;
        int     hs0;

        //          mode  a      b      c      d      e      f      x      y      z      ovf
        tbl[0] = '{2'd0, 8'd12, 8'd2, 8'hA9, 8'd8, 8'hB4, 8'd2, 8'd14, 8'd177, 8'd182, 3'b000};
        tbl[1] = '{2'd1, 8'd12, 8'd2, 8'hA9, 8'd8, 8'hB4, 8'd2, 8'd10, 8'd161, 8'd178, 3'b000};
        tbl[2] = '{2'd0, 8'd200, 8'd100, 8'hA9, 8'd8, 8'hB4, 8'd2, 8'd44, 8'd177, 8'd182, 3'b001};
        tbl[3] = '{2'd1, 8'd12, 8'd2, 8'd8, 8'hA9, 8'hB4, 8'd2, 8'd10, 8'd95, 8'd178, 3'b010};
        tbl[4] = '{2'd2, 8'd12, 8'd2, 8'hA9, 8'd8, 8'hB4, 8'd2, 8'd0, 8'hA9, 8'hB6, 3'b000};
        tbl[5] = '{2'd3, 8'd12, 8'd2, 8'hA9, 8'd8, 8'hB4, 8'd2, 8'd12, 8'd8, 8'd91, 3'b000};
        tbl[6] = '{2'd0, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 3'b011};
        tbl[7] = '{2'd1, 8'h00, 8'h01, 8'h05, 8'h05, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01, 3'b101};
        tbl[8] = '{2'd3, 8'd3, 8'd200, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'd200, 8'h00, 8'hFF, 3'b000};
        tbl[9] = '{2'd2, 8'hF0, 8'h3C, 8'hF0, 8'h0F, 8'hAA, 8'hFF, 8'h30, 8'hFF, 8'h55, 3'b000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = '0;
        a = '0; b = '0; c = '0; d = '0; e = '0; f = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_xyz", {x, y, z}, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done_cnt", done_cnt, 0);

        // Latency: set presented in cycle k, results valid in cycle k+2
        @(posedge clk);
        #1 drive(tbl[0]);
        @(negedge clk);
        chk("lat_accept", in_ready, 1);
        exp_q.push_back(exp_of(tbl[0]));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_not_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        @(negedge clk);
        chk("lat_done_cnt", done_cnt, 1);
        chk("lat_out_cleared", out_valid, 0);
        @(posedge clk);
        #1;

        // Table vectors back to back, mode changing every set
        for (int i = 1; i < 10; i++) send(tbl[i]);
        drain();

        // Backpressure: two sets fill the pipe, third is refused, outputs frozen
        clean_reset();
        out_ready = 1'b0;
        drive(tbl[0]);
        @(negedge clk);
        chk("bp_accept0", in_ready, 1);
        exp_q.push_back(exp_of(tbl[0]));
        @(posedge clk);
        #1 drive(tbl[1]);
        @(negedge clk);
        chk("bp_accept1", in_ready, 1);
        exp_q.push_back(exp_of(tbl[1]));
        @(posedge clk);
        #1 drive(tbl[2]);
        @(negedge clk);
        chk("bp_third_refused", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_x", x, tbl[0].ex);
            chk("bp_hold_yz", {y, z, 5'd0, ovf}, {tbl[0].ey, tbl[0].ez, 5'd0, tbl[0].eovf});
            chk("bp_still_full", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", in_ready, 1);
        exp_q.push_back(exp_of(tbl[2]));
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("bp_done_cnt", done_cnt, 3);

        // Streaming 16 model-checked sets; counter passes 15 -> 0 on the way
        hs0 = hs_total;
        max_run = 0;
        t0 = $time;
        for (int i = 0; i < 16; i++) begin
            v.mode = 2'($urandom_range(3));
            v.a = W'($urandom); v.b = W'($urandom); v.c = W'($urandom);
            v.d = W'($urandom); v.e = W'($urandom); v.f = W'($urandom);
            v.ex = '0; v.ey = '0; v.ez = '0; v.eovf = '0;
            send(modelled(v));
        end
        chk("stream_cycles", 32'(($time - t0) / 10), 16);
        drain();
        chk("stream_handshakes", hs_total - hs0, 16);
        chk("stream_run", (max_run >= 16) ? 1 : 0, 1);
        chk("cnt_wrapped", done_cnt, (3 + 16) % 16);

        // Reset asserted with two sets in flight
        out_ready = 1'b0;
        send(tbl[3]);
        send(tbl[4]);
        #3 rst_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_xyz", {x, y, z}, 0);
        chk("async_rst_ovf", ovf, 0);
        chk("async_rst_cnt", done_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_no_output", out_valid, 0);
        @(posedge clk);
        #1 send(tbl[5]);
        drain();
        chk("post_rst_done_cnt", done_cnt, 1);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
